// File: rtl/serial_tx_pal_if.sv
// Load channel of the serial transmitter: valid/ready word handshake.
// Master drives the word, slave (the transmitter) returns ready.
interface serial_tx_pal_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/serial_tx_pal.sv
// Parallel-to-serial transmitter, MSB first, one bit per en cycle.
// Define PARITY_EN to append an even-parity bit after the data bits.
module serial_tx_pal #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  serial_tx_pal_if.slave ld,
  input  logic           en,
  output logic           out,
  output logic           out_valid,
  output logic           busy,
  output logic           done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
`ifdef PARITY_EN
  logic             par;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
`ifdef PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld.load_valid) begin
            shreg <= ld.load_data;
            cnt   <= '0;
            state <= SHIFT;
`ifdef PARITY_EN
            par   <= ^ld.load_data;
`endif
          end
        end
        SHIFT: begin
          // a count past the last bit can only come from corruption
          if (cnt > LAST) begin
            state <= IDLE;
          end else if (en) begin
            shreg <= shreg << 1;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) begin
`ifdef PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (en) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    out       = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == SHIFT): begin
        out       = shreg[WIDTH-1];
        out_valid = en;
      end
`ifdef PARITY_EN
      (state == PARITY): begin
        out       = par;
        out_valid = en;
      end
`endif
      default: ;
    endcase
  end

  assign busy          = (state != IDLE);
  assign ld.load_ready = (state == IDLE);
endmodule

// File: tb/tb_serial_tx_pal.sv
// Directed bench for serial_tx_pal with a reference 4-bit receiver.
// Parity scenario runs only when PARITY_EN is defined.
module tb_serial_tx_pal;
  logic clk;
  logic reset_n;
  logic en;
  logic out;
  logic out_valid;
  logic busy;
  logic done;
  logic [7:0] rx;
  int checks;
  int errors;

  serial_tx_pal_if #(.WIDTH(4)) ld_if ();

  serial_tx_pal #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ld       (ld_if.slave),
    .en       (en),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // receiver: captures a bit on every strobed cycle
  always @(negedge clk)
    if (out_valid === 1'b1) rx = {rx[6:0], out};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] d);
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = d;
    tick();
    ld_if.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    ld_if.load_valid = 1'b0;
    ld_if.load_data  = '0;
    en = 1'b0;
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    tick();
    #1;
    checks++;
    if (out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || ld_if.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle out=%b ov=%b busy=%b done=%b rdy=%b need 0 0 0 0 1",
               out, out_valid, busy, done, ld_if.load_ready);
    end
    en = 1'b1;
    load_word(4'hF);
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || ld_if.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async out=%b ov=%b busy=%b done=%b rdy=%b need 0 0 0 0 1",
               out, out_valid, busy, done, ld_if.load_ready);
    end
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] w;
    w = 4'hB;
    en = 1'b1;
    rx = '0;
    load_word(w);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out !== w[3-i] || out_valid !== 1'b1 || busy !== 1'b1 ||
          ld_if.load_ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_bit%0d out=%b ov=%b busy=%b rdy=%b done=%b need %b 1 1 0 0",
                 i, out, out_valid, busy, ld_if.load_ready, done, w[3-i]);
      end
      tick();
    end
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ld_if.load_ready !== 1'b1 ||
        out_valid !== 1'b0 || out !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done=%b busy=%b rdy=%b ov=%b out=%b need 1 0 1 0 0",
               done, busy, ld_if.load_ready, out_valid, out);
    end
    checks++;
    if (rx[3:0] !== 4'hB) begin
      errors++;
      $display("FAIL basic_rx got %h need b", rx[3:0]);
    end
    tick();
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse done=%b need 0", done);
    end
  endtask

  task automatic test_stall();
    logic [3:0] w;
    w = 4'h6;
    en = 1'b1;
    rx = '0;
    load_word(w);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (out !== w[3-i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_pre%0d out=%b ov=%b need %b 1", i, out, out_valid, w[3-i]);
      end
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d out=%b ov=%b busy=%b done=%b need 1 0 1 0",
                 i, out, out_valid, busy, done);
      end
      tick();
    end
    en = 1'b1;
    for (int i = 2; i < 4; i++) begin
      #1;
      checks++;
      if (out !== w[3-i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_post%0d out=%b ov=%b need %b 1", i, out, out_valid, w[3-i]);
      end
      tick();
    end
    #1;
    checks++;
    if (done !== 1'b1 || rx[3:0] !== 4'h6) begin
      errors++;
      $display("FAIL stall_end done=%b rx=%h need 1 6", done, rx[3:0]);
    end
    tick();
  endtask

  task automatic test_busy_load();
    logic [3:0] w;
    w = 4'h3;
    en = 1'b1;
    rx = '0;
    load_word(w);
    for (int i = 0; i < 4; i++) begin
      ld_if.load_valid = (i == 1);
      ld_if.load_data  = 4'hF;
      #1;
      checks++;
      if (out !== w[3-i] || out_valid !== 1'b1 || ld_if.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_bit%0d out=%b ov=%b rdy=%b need %b 1 0",
                 i, out, out_valid, ld_if.load_ready, w[3-i]);
      end
      tick();
    end
    ld_if.load_valid = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || ld_if.load_ready !== 1'b1 || rx[3:0] !== 4'h3) begin
      errors++;
      $display("FAIL busy_end done=%b rdy=%b rx=%h need 1 1 3",
               done, ld_if.load_ready, rx[3:0]);
    end
    load_word(4'h9);
    #1;
    checks++;
    if (busy !== 1'b1 || out !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL busy_reload busy=%b out=%b ov=%b need 1 1 1", busy, out, out_valid);
    end
    repeat (5) tick();
  endtask

  task automatic test_abort();
    logic [3:0] w;
    en = 1'b1;
    load_word(4'hA);
    tick();
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_now busy=%b ov=%b done=%b need 0 0 0", busy, out_valid, done);
    end
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle%0d done=%b busy=%b need 0 0", i, done, busy);
      end
    end
    w = 4'h5;
    rx = '0;
    load_word(w);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out !== w[3-i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL abort_bit%0d out=%b ov=%b need %b 1", i, out, out_valid, w[3-i]);
      end
      tick();
    end
    #1;
    checks++;
    if (done !== 1'b1 || rx[3:0] !== 4'h5) begin
      errors++;
      $display("FAIL abort_end done=%b rx=%h need 1 5", done, rx[3:0]);
    end
    tick();
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [3:0] w;
    logic [4:0] fr;
    w  = 4'hB;
    fr = 5'b10111;
    en = 1'b1;
    rx = '0;
    load_word(w);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (out !== fr[4-i] || out_valid !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL parity_bit%0d out=%b ov=%b done=%b need %b 1 0",
                 i, out, out_valid, done, fr[4-i]);
      end
      tick();
    end
    #1;
    checks++;
    if (done !== 1'b1 || rx[4:0] !== 5'b10111) begin
      errors++;
      $display("FAIL parity_end done=%b rx=%b need 1 10111", done, rx[4:0]);
    end
    tick();
    load_word(4'h9);
    repeat (4) tick();
    #1;
    checks++;
    if (out !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL parity_zero out=%b ov=%b busy=%b need 0 1 1", out, out_valid, busy);
    end
    tick();
    tick();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rx = '0;
    test_reset();
    test_basic();
    test_stall();
    test_busy_load();
    test_abort();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
